// File: rtl/sdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pkg
//  Description : Shared types, mode-register fields and helpers for the
//                cycle-level SDR SDRAM bank model.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_pkg;

    // Command encoding is the raw {ras, cas, nwe} pin triple.
    typedef enum logic [2:0] {
        CMD_MRS       = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVATE  = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_BST       = 3'b110,
        CMD_NOP       = 3'b111
    } cmd_t;

    typedef enum logic [1:0] {
        BANK_IDLE       = 2'd0,
        BANK_ACTIVATING = 2'd1,
        BANK_ACTIVE     = 2'd2
    } bank_state_t;

    localparam int MODE_FIELD_BITS    = 3;
    localparam int MODE_BL_LSB        = 0;
    localparam int MODE_CL_LSB        = 4;
    localparam int AUTO_PRECHARGE_BIT = 10;

    localparam logic [2:0] BL_CODE_1 = 3'd0;
    localparam logic [2:0] BL_CODE_2 = 3'd1;
    localparam logic [2:0] BL_CODE_4 = 3'd2;
    localparam logic [2:0] BL_CODE_8 = 3'd3;
    localparam logic [2:0] CL_CODE_2 = 3'd2;
    localparam logic [2:0] CL_CODE_3 = 3'd3;

    function automatic logic [3:0] burst_length(input logic [2:0] code);
        case (code)
            BL_CODE_2: return 4'd2;
            BL_CODE_4: return 4'd4;
            BL_CODE_8: return 4'd8;
            default:   return 4'd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_bank_model_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_bank_model_if
//  Description : SDRAM pin bundle between a controller (master) and the model.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_bank_model_if #(
    parameter int DATA_WIDTH         = 32,
    parameter int ROW_BITS           = 11,
    parameter int BANK_BITS          = 2,
    parameter int REFRESH_COUNT_BITS = 16
);
    logic                          cke;
    logic [ROW_BITS-1:0]           address;
    logic [BANK_BITS-1:0]          ba;
    logic                          ncs;
    logic                          ras;
    logic                          cas;
    logic                          nwe;
    logic [DATA_WIDTH/8-1:0]       dqm;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [DATA_WIDTH-1:0]         data_out;
    logic                          data_out_valid;
    logic                          protocol_error;
    logic [REFRESH_COUNT_BITS-1:0] refresh_count;

    modport master (
        output cke, address, ba, ncs, ras, cas, nwe, dqm, data_in,
        input  data_out, data_out_valid, protocol_error, refresh_count
    );

    modport slave (
        input  cke, address, ba, ncs, ras, cas, nwe, dqm, data_in,
        output data_out, data_out_valid, protocol_error, refresh_count
    );
endinterface
`default_nettype wire

// File: rtl/sdram_read_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_read_pipe
//  Description : 3-stage {valid, data} delay line with CAS-latency tap and a
//                holding output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_read_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  en,
    input  logic                  cl3,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  pending
);
    localparam int STAGES = 3;

    logic [STAGES-1:0]     r_valid;
    logic [DATA_WIDTH-1:0] r_data [STAGES];
    logic                  w_tap_valid;
    logic [DATA_WIDTH-1:0] w_tap_data;

    // Output register adds the final cycle, so the tap sits at stage CL-1.
    assign w_tap_valid = cl3 ? r_valid[2] : r_valid[1];
    assign w_tap_data  = cl3 ? r_data[2]  : r_data[1];
    assign pending     = cl3 ? (|r_valid) : (|r_valid[1:0]);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_valid   <= '0;
            for (int s = 0; s < STAGES; s++) r_data[s] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            r_valid   <= {r_valid[STAGES-2:0], in_valid};
            r_data[0] <= in_data;
            for (int s = 1; s < STAGES; s++) r_data[s] <= r_data[s-1];
            out_valid <= w_tap_valid;
            if (w_tap_valid) out_data <= w_tap_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/sdram_bank_model.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_bank_model
//  Description : Cycle-level SDR SDRAM model: per-bank row tracking, mode
//                register, bursts, refresh and a sticky protocol-error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_bank_model
    import sdram_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int ROW_BITS           = 11,
    parameter int COLUMN_BITS        = 8,
    parameter int BANK_BITS          = 2,
    parameter int TRCD               = 2,
    parameter int REFRESH_COUNT_BITS = 16
) (
    input  logic               clk,
    input  logic               nreset,
    sdram_bank_model_if.slave  bus
);
    localparam int LANES     = DATA_WIDTH / 8;
    localparam int BANKS     = 1 << BANK_BITS;
    localparam int ADDR_BITS = BANK_BITS + ROW_BITS + COLUMN_BITS;
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam int CNT_BITS  = $clog2(TRCD) + 1;

    bank_state_t                   r_state [BANKS];
    logic [ROW_BITS-1:0]           r_row   [BANKS];
    logic [CNT_BITS-1:0]           r_cnt   [BANKS];
    logic [2:0]                    r_bl_code;
    logic [2:0]                    r_cl_code;
    logic                          r_burst_active;
    logic                          r_burst_write;
    logic                          r_burst_ap;
    logic [BANK_BITS-1:0]          r_burst_bank;
    logic [ROW_BITS-1:0]           r_burst_row;
    logic [COLUMN_BITS-1:0]        r_burst_col;
    logic [3:0]                    r_beats_left;
    logic                          r_protocol_error;
    logic [REFRESH_COUNT_BITS-1:0] r_refresh_count;

    cmd_t                   w_cmd;
    logic                   w_all_idle;
    logic                   w_bank_active;
    logic                   w_rw_ok;
    logic                   w_precharge_hits;
    logic                   w_burst_step;
    logic [3:0]             w_len;
    logic [COLUMN_BITS-1:0] w_wrap_mask;
    logic [COLUMN_BITS-1:0] w_start_col;
    logic [2:0]             w_mode_bl;
    logic [2:0]             w_mode_cl;
    logic                   w_mem_wr;
    logic                   w_mem_rd;
    logic [ADDR_BITS-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]  w_fetch_data;
    logic                   w_rd_pending;
    logic                   w_out_valid;
    logic [DATA_WIDTH-1:0]  w_out_data;

    // Sequential column order wraps inside the burst-aligned block.
    function automatic logic [COLUMN_BITS-1:0] next_col(
        input logic [COLUMN_BITS-1:0] col,
        input logic [COLUMN_BITS-1:0] mask
    );
        logic [COLUMN_BITS-1:0] inc;
        inc = col + COLUMN_BITS'(1);
        return (col & ~mask) | (inc & mask);
    endfunction

    assign w_cmd            = (bus.cke && !bus.ncs) ? cmd_t'({bus.ras, bus.cas, bus.nwe}) : CMD_NOP;
    assign w_len            = burst_length(r_bl_code);
    assign w_wrap_mask      = COLUMN_BITS'(w_len - 4'd1);
    assign w_start_col      = bus.address[COLUMN_BITS-1:0];
    assign w_mode_bl        = bus.address[MODE_BL_LSB +: MODE_FIELD_BITS];
    assign w_mode_cl        = bus.address[MODE_CL_LSB +: MODE_FIELD_BITS];
    assign w_bank_active    = (r_state[bus.ba] == BANK_ACTIVE);
    assign w_rw_ok          = ((w_cmd == CMD_READ) || (w_cmd == CMD_WRITE)) && w_bank_active;
    assign w_precharge_hits = (w_cmd == CMD_PRECHARGE) &&
                              (bus.address[AUTO_PRECHARGE_BIT] || (bus.ba == r_burst_bank));
    assign w_burst_step     = bus.cke && r_burst_active &&
                              !(w_rw_ok || (w_cmd == CMD_BST) || w_precharge_hits);

    always_comb begin
        w_all_idle = 1'b1;
        for (int b = 0; b < BANKS; b++) begin
            if (r_state[b] != BANK_IDLE) w_all_idle = 1'b0;
        end
    end

    always_comb begin
        w_mem_wr   = 1'b0;
        w_mem_rd   = 1'b0;
        w_mem_addr = '0;
        if (w_rw_ok) begin
            w_mem_addr = {bus.ba, r_row[bus.ba], w_start_col};
            w_mem_wr   = (w_cmd == CMD_WRITE);
            w_mem_rd   = (w_cmd == CMD_READ);
        end else if (w_burst_step) begin
            w_mem_addr = {r_burst_bank, r_burst_row, r_burst_col};
            w_mem_wr   = r_burst_write;
            w_mem_rd   = !r_burst_write;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive nreset.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (w_mem_wr && !bus.dqm[l]) mem[w_mem_addr] <= bus.data_in[8*l +: 8];
        end
        assign w_fetch_data[8*l +: 8] = bus.dqm[l] ? 8'h00 : mem[w_mem_addr];
    end

    sdram_read_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_read_pipe (
        .clk       (clk),
        .nreset    (nreset),
        .en        (bus.cke),
        .cl3       (r_cl_code == CL_CODE_3),
        .in_valid  (w_mem_rd),
        .in_data   (w_fetch_data),
        .out_valid (w_out_valid),
        .out_data  (w_out_data),
        .pending   (w_rd_pending)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int b = 0; b < BANKS; b++) begin
                r_state[b] <= BANK_IDLE;
                r_row[b]   <= '0;
                r_cnt[b]   <= '0;
            end
            r_bl_code        <= BL_CODE_1;
            r_cl_code        <= CL_CODE_2;
            r_burst_active   <= 1'b0;
            r_burst_write    <= 1'b0;
            r_burst_ap       <= 1'b0;
            r_burst_bank     <= '0;
            r_burst_row      <= '0;
            r_burst_col      <= '0;
            r_beats_left     <= '0;
            r_protocol_error <= 1'b0;
            r_refresh_count  <= '0;
        end else if (bus.cke) begin
            for (int b = 0; b < BANKS; b++) begin
                if (r_state[b] == BANK_ACTIVATING) begin
                    if (r_cnt[b] == CNT_BITS'(1)) r_state[b] <= BANK_ACTIVE;
                    r_cnt[b] <= r_cnt[b] - CNT_BITS'(1);
                end
            end

            if (w_burst_step) begin
                r_burst_col  <= next_col(r_burst_col, w_wrap_mask);
                r_beats_left <= r_beats_left - 4'd1;
                if (r_beats_left == 4'd1) begin
                    r_burst_active <= 1'b0;
                    if (r_burst_ap) r_state[r_burst_bank] <= BANK_IDLE;
                end
            end else begin
                r_burst_active <= 1'b0;
            end

            // Command handling comes last so it overrides the burst bookkeeping above.
            case (w_cmd)
                CMD_ACTIVATE: begin
                    if (r_state[bus.ba] != BANK_IDLE) begin
                        r_protocol_error <= 1'b1;
                    end else begin
                        r_row[bus.ba] <= bus.address;
                        r_cnt[bus.ba] <= CNT_BITS'(TRCD - 1);
                        r_state[bus.ba] <= (TRCD <= 1) ? BANK_ACTIVE : BANK_ACTIVATING;
                    end
                end
                CMD_READ, CMD_WRITE: begin
                    if (!w_bank_active) begin
                        r_protocol_error <= 1'b1;
                    end else begin
                        if ((w_cmd == CMD_WRITE) && w_rd_pending) r_protocol_error <= 1'b1;
                        r_burst_active <= (w_len != 4'd1);
                        r_burst_write  <= (w_cmd == CMD_WRITE);
                        r_burst_ap     <= bus.address[AUTO_PRECHARGE_BIT];
                        r_burst_bank   <= bus.ba;
                        r_burst_row    <= r_row[bus.ba];
                        r_burst_col    <= next_col(w_start_col, w_wrap_mask);
                        r_beats_left   <= w_len - 4'd1;
                        if ((w_len == 4'd1) && bus.address[AUTO_PRECHARGE_BIT])
                            r_state[bus.ba] <= BANK_IDLE;
                    end
                end
                CMD_PRECHARGE: begin
                    if (bus.address[AUTO_PRECHARGE_BIT]) begin
                        for (int b = 0; b < BANKS; b++) r_state[b] <= BANK_IDLE;
                    end else begin
                        r_state[bus.ba] <= BANK_IDLE;
                    end
                end
                CMD_REFRESH: begin
                    if (w_all_idle) r_refresh_count <= r_refresh_count + REFRESH_COUNT_BITS'(1);
                    else            r_protocol_error <= 1'b1;
                end
                CMD_MRS: begin
                    if (!w_all_idle) begin
                        r_protocol_error <= 1'b1;
                    end else begin
                        if (w_mode_bl <= BL_CODE_8) r_bl_code <= w_mode_bl;
                        else                        r_protocol_error <= 1'b1;
                        if ((w_mode_cl == CL_CODE_2) || (w_mode_cl == CL_CODE_3)) r_cl_code <= w_mode_cl;
                        else                                                      r_protocol_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out       = w_out_data;
    assign bus.data_out_valid = w_out_valid;
    assign bus.protocol_error = r_protocol_error;
    assign bus.refresh_count  = r_refresh_count;
endmodule
`default_nettype wire

// File: tb/tb_sdram_bank_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_bank_model
//  Description : Directed bench with an expected-beat scoreboard for the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_bank_model;
    import sdram_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic nreset;
    int   cyc;
    int   n_vec;
    int   n_err;
    exp_t q[$];
    exp_t m_e;
    int   t;

    sdram_bank_model_if #(
        .DATA_WIDTH(32), .ROW_BITS(11), .BANK_BITS(2), .REFRESH_COUNT_BITS(16)
    ) bus ();

    sdram_bank_model #(
        .DATA_WIDTH(32), .ROW_BITS(11), .COLUMN_BITS(8), .BANK_BITS(2),
        .TRCD(2), .REFRESH_COUNT_BITS(16)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every presented beat must match the queue head in data and cycle.
    always @(negedge clk) begin
        if (bus.data_out_valid !== 1'b0) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat: got data %h at cycle %0d, required no beat", bus.data_out, cyc);
            end else begin
                m_e = q.pop_front();
                if ((bus.data_out !== m_e.data) || (cyc != m_e.cyc)) begin
                    n_err++;
                    $display("FAIL read_beat: got %h at cycle %0d, required %h at cycle %0d",
                             bus.data_out, cyc, m_e.data, m_e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [10:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        bus.ncs     = 1'b0;
        bus.ras     = c[2];
        bus.cas     = c[1];
        bus.nwe     = c[0];
        bus.ba      = b;
        bus.address = a;
        bus.data_in = d;
        bus.dqm     = m;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        repeat (n) issue(CMD_NOP, 2'd0, 11'h000, 32'h0, 4'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        nreset = 1'b0;
        bus.cke = 1'b1;
        bus.ncs = 1'b1;
        bus.ras = 1'b1;
        bus.cas = 1'b1;
        bus.nwe = 1'b1;
        bus.ba = '0;
        bus.address = '0;
        bus.dqm = '0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(bus.data_out_valid), 32'h0);
        check("reset_data", bus.data_out, 32'h0);
        check("reset_error", 32'(bus.protocol_error), 32'h0);
        check("reset_refresh", 32'(bus.refresh_count), 32'h0);
        nreset = 1'b1;

        // BL=4, CL=3; burst write then two wrapped reads
        issue(CMD_MRS, 2'd0, 11'h032, 32'h0, 4'h0);
        issue(CMD_ACTIVATE, 2'd1, 11'h123, 32'h0, 4'h0);
        nop(1);
        issue(CMD_WRITE, 2'd1, 11'h006, 32'h11, 4'h0);
        issue(CMD_NOP, 2'd0, 11'h000, 32'h22, 4'h0);
        issue(CMD_NOP, 2'd0, 11'h000, 32'h33, 4'h0);
        issue(CMD_NOP, 2'd0, 11'h000, 32'h44, 4'h0);
        issue(CMD_READ, 2'd1, 11'h006, 32'h0, 4'h0);
        t = cyc;
        push(32'h11, t + 3); push(32'h22, t + 4); push(32'h33, t + 5); push(32'h44, t + 6);
        nop(3);
        issue(CMD_READ, 2'd1, 11'h004, 32'h0, 4'h0);
        t = cyc;
        push(32'h33, t + 3); push(32'h44, t + 4); push(32'h11, t + 5); push(32'h22, t + 6);
        nop(8);
        check("no_error_basic", 32'(bus.protocol_error), 32'h0);

        // Byte masks on write and read
        issue(CMD_WRITE, 2'd1, 11'h010, 32'h00000000, 4'h0);
        issue(CMD_NOP, 2'd0, 11'h000, 32'h12345678, 4'h0);
        issue(CMD_NOP, 2'd0, 11'h000, 32'h9ABCDEF0, 4'h0);
        issue(CMD_NOP, 2'd0, 11'h000, 32'h0F1E2D3C, 4'h0);
        issue(CMD_WRITE, 2'd1, 11'h010, 32'hAABBCCDD, 4'b0101);
        repeat (3) issue(CMD_NOP, 2'd0, 11'h000, 32'hFFFFFFFF, 4'b1111);
        nop(1);
        issue(CMD_READ, 2'd1, 11'h010, 32'h0, 4'h0);
        t = cyc;
        push(32'hAA00CC00, t + 3); push(32'h12345678, t + 4);
        push(32'h9ABCDEF0, t + 5); push(32'h0F1E2D3C, t + 6);
        nop(3);
        issue(CMD_READ, 2'd1, 11'h011, 32'h0, 4'b1000);
        t = cyc;
        issue(CMD_NOP, 2'd0, 11'h000, 32'h0, 4'b0001);
        push(32'h00345678, t + 3); push(32'h9ABCDE00, t + 4);
        push(32'h0F1E2D3C, t + 5); push(32'hAA00CC00, t + 6);
        nop(8);

        // READ inside tRCD is rejected; the next one is legal
        issue(CMD_PRECHARGE, 2'd1, 11'h000, 32'h0, 4'h0);
        issue(CMD_ACTIVATE, 2'd1, 11'h123, 32'h0, 4'h0);
        issue(CMD_READ, 2'd1, 11'h004, 32'h0, 4'h0);
        check("trcd_error", 32'(bus.protocol_error), 32'h1);
        issue(CMD_READ, 2'd1, 11'h004, 32'h0, 4'h0);
        t = cyc;
        push(32'h33, t + 3); push(32'h44, t + 4); push(32'h11, t + 5); push(32'h22, t + 6);
        nop(6);

        // Reset in the middle of a read burst
        issue(CMD_READ, 2'd1, 11'h006, 32'h0, 4'h0);
        t = cyc;
        push(32'h11, t + 3);
        nop(4);
        nreset = 1'b0;
        #1;
        check("midreset_valid", 32'(bus.data_out_valid), 32'h0);
        check("midreset_data", bus.data_out, 32'h0);
        check("midreset_error", 32'(bus.protocol_error), 32'h0);
        check("midreset_refresh", 32'(bus.refresh_count), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;

        // Memory survives reset; mode is back to BL=1, CL=2
        issue(CMD_ACTIVATE, 2'd1, 11'h123, 32'h0, 4'h0);
        nop(1);
        issue(CMD_READ, 2'd1, 11'h006, 32'h0, 4'h0);
        t = cyc;
        push(32'h11, t + 2);
        nop(4);

        // BL=8, CL=2 read cut short by BURST TERMINATE after two fetches
        issue(CMD_PRECHARGE, 2'd0, 11'h400, 32'h0, 4'h0);
        issue(CMD_MRS, 2'd0, 11'h023, 32'h0, 4'h0);
        issue(CMD_ACTIVATE, 2'd1, 11'h123, 32'h0, 4'h0);
        nop(1);
        issue(CMD_READ, 2'd1, 11'h004, 32'h0, 4'h0);
        t = cyc;
        push(32'h33, t + 2); push(32'h44, t + 3);
        nop(1);
        issue(CMD_BST, 2'd0, 11'h000, 32'h0, 4'h0);
        nop(6);
        check("bst_no_error", 32'(bus.protocol_error), 32'h0);

        // Refresh accounting and refresh with an open bank
        issue(CMD_PRECHARGE, 2'd0, 11'h400, 32'h0, 4'h0);
        repeat (3) issue(CMD_REFRESH, 2'd0, 11'h000, 32'h0, 4'h0);
        check("refresh_count", 32'(bus.refresh_count), 32'd3);
        check("refresh_no_error", 32'(bus.protocol_error), 32'h0);
        issue(CMD_ACTIVATE, 2'd0, 11'h001, 32'h0, 4'h0);
        nop(2);
        issue(CMD_REFRESH, 2'd0, 11'h000, 32'h0, 4'h0);
        check("refresh_busy_error", 32'(bus.protocol_error), 32'h1);
        check("refresh_busy_count", 32'(bus.refresh_count), 32'd3);

        nop(5);
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
